// File: rtl/data_buffer_pkg.sv
// ============================================================================
// Module   : data_buffer_pkg
// Purpose  : Shared types and helpers for the parametrised data buffer.
//            - Transfer-size encoding used by both bus-side strobes.
//            - Byte-count decode for that encoding.
//            - Default depth and bus lane count.
// Ports    : none (package)
// Options  : DATA_BUFFER_ERR_FLAGS_EN (consumed by param_data_buffer)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_buffer_pkg;

  localparam int DEF_DEPTH     = 64;
  localparam int DEF_BUS_BYTES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } xfer_size_t;

  // Bytes moved by one bus strobe; the reserved code moves nothing.
  function automatic logic [2:0] size_bytes(input xfer_size_t sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_buffer_mem.sv
// ============================================================================
// Module   : data_buffer_mem
// Purpose  : Byte RAM for the data buffer. Up to BUS_BYTES bytes are written
//            per cycle at consecutive modulo-DEPTH addresses, and either a
//            multi-lane bus read or a single packet byte is registered per
//            cycle. Read registers hold between accepted reads.
// Ports    : clk, n_rst      - clock, async active-low reset
//            clr             - synchronous zeroing of both read registers
//            wr_n/wr_ptr     - byte count and start address of a write
//            wr_data         - write lanes, lane 0 = [7:0]
//            bus_rd/pkt_rd   - load bus / packet read register
//            rd_n/rd_ptr     - byte count and start address of a read
//            bus_q           - bus read register, lanes >= rd_n are 0
//            pkt_q           - packet read register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_buffer_mem
  import data_buffer_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int BUS_BYTES = DEF_BUS_BYTES,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clr,
  input  logic [2:0]             wr_n,
  input  logic [PTR_W-1:0]       wr_ptr,
  input  logic [8*BUS_BYTES-1:0] wr_data,
  input  logic                   bus_rd,
  input  logic                   pkt_rd,
  input  logic [2:0]             rd_n,
  input  logic [PTR_W-1:0]       rd_ptr,
  output logic [8*BUS_BYTES-1:0] bus_q,
  output logic [7:0]             pkt_q
);

  logic [7:0]             ram [DEPTH];
  logic [8*BUS_BYTES-1:0] rd_lanes;

  // Address arithmetic is PTR_W wide so a straddling access wraps to 0.
  always_ff @(posedge clk) begin : p_ram_wr
    for (int k = 0; k < BUS_BYTES; k++) begin
      if (k < int'(wr_n)) begin
        ram[wr_ptr + PTR_W'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin : p_rd_lanes
    rd_lanes = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      if (k < int'(rd_n)) begin
        rd_lanes[8*k +: 8] = ram[rd_ptr + PTR_W'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin : p_rd_regs
    if (!n_rst) begin
      bus_q <= '0;
      pkt_q <= '0;
    end else if (clr) begin
      bus_q <= '0;
      pkt_q <= '0;
    end else begin
      if (bus_rd) bus_q <= rd_lanes;
      if (pkt_rd) pkt_q <= ram[rd_ptr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_data_buffer.sv
// ============================================================================
// Module   : param_data_buffer
// Purpose  : Circular byte FIFO between a USB packet side (one byte per
//            strobe) and an AHB-lite bus side (1/2/4 bytes per strobe,
//            little-endian). Transfers are all-or-nothing.
// Ports    : clk, n_rst                       - clock, async active-low reset
//            clear / flush                    - empty buffer (clear also
//                                               zeroes data outputs, flags)
//            store_rx_packet_data/rx_packet_data - packet-side push
//            get_tx_packet_data/tx_packet_data   - packet-side pop
//            store_tx_data/tx_size/tx_data    - bus-side push
//            get_rx_data/rx_size/rx_data      - bus-side pop
//            buffer_occupancy, full, empty    - fill status
//            overflow, underflow              - sticky rejection flags
// Options  : DATA_BUFFER_ERR_FLAGS_EN - when defined the sticky flags are
//            built; otherwise overflow/underflow are tied 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_data_buffer
  import data_buffer_pkg::*;
#(
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int BUS_BYTES = DEF_BUS_BYTES,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   flush,
  input  logic                   store_rx_packet_data,
  input  logic [7:0]             rx_packet_data,
  input  logic                   get_tx_packet_data,
  output logic [7:0]             tx_packet_data,
  input  logic                   store_tx_data,
  input  logic [1:0]             tx_size,
  input  logic [8*BUS_BYTES-1:0] tx_data,
  input  logic                   get_rx_data,
  input  logic [1:0]             rx_size,
  output logic [8*BUS_BYTES-1:0] rx_data,
  output logic [OCC_W-1:0]       buffer_occupancy,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CALC_W = OCC_W + 1;

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occ;
  logic [2:0]             wr_n;
  logic [2:0]             rd_n;
  logic [2:0]             wr_acc;
  logic [2:0]             rd_acc;
  logic                   rd_ok;
  logic                   wr_ok;
  logic                   hold;
  logic [CALC_W-1:0]      occ_after;
  logic [8*BUS_BYTES-1:0] wr_data;

  // Sizes wider than the bus are treated like the reserved code: no move.
  function automatic logic [2:0] lane_count(input logic [1:0] sz);
    logic [2:0] n;
    n = size_bytes(xfer_size_t'(sz));
    return (int'(n) > BUS_BYTES) ? 3'd0 : n;
  endfunction

  always_comb begin : p_accept
    hold = clear || flush;

    // Bus strobes win over packet strobes on both push and pop sides.
    wr_n = store_tx_data ? lane_count(tx_size)
                         : (store_rx_packet_data ? 3'd1 : 3'd0);
    rd_n = get_rx_data   ? lane_count(rx_size)
                         : (get_tx_packet_data ? 3'd1 : 3'd0);

    // Pops see only start-of-cycle occupancy; a same-cycle pop frees room
    // for the push.
    rd_ok     = !hold && (rd_n != 3'd0) && (CALC_W'(rd_n) <= CALC_W'(occ));
    rd_acc    = rd_ok ? rd_n : 3'd0;
    occ_after = CALC_W'(occ) - CALC_W'(rd_acc) + CALC_W'(wr_n);
    wr_ok     = !hold && (wr_n != 3'd0) && (occ_after <= CALC_W'(DEPTH));
    wr_acc    = wr_ok ? wr_n : 3'd0;

    wr_data        = '0;
    wr_data[7:0]   = rx_packet_data;
    if (store_tx_data) wr_data = tx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin : p_ctrl
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (hold) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_acc);
      rd_ptr <= rd_ptr + PTR_W'(rd_acc);
      occ    <= occ + OCC_W'(wr_acc) - OCC_W'(rd_acc);
    end
  end

  data_buffer_mem #(
    .DEPTH     (DEPTH),
    .BUS_BYTES (BUS_BYTES)
  ) u_mem (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (clear),
    .wr_n    (wr_acc),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .bus_rd  (rd_ok && get_rx_data),
    .pkt_rd  (rd_ok && !get_rx_data),
    .rd_n    (rd_acc),
    .rd_ptr  (rd_ptr),
    .bus_q   (rx_data),
    .pkt_q   (tx_packet_data)
  );

  assign buffer_occupancy = occ;
  assign full             = (occ == OCC_W'(DEPTH));
  assign empty            = (occ == '0);

`ifdef DATA_BUFFER_ERR_FLAGS_EN
  logic push_rej;
  logic pop_rej;
  logic ovf_flag;
  logic unf_flag;

  // Reserved sizes give a zero count and so never count as a rejection.
  assign push_rej = !hold && (wr_n != 3'd0) && !wr_ok;
  assign pop_rej  = !hold && (rd_n != 3'd0) && !rd_ok;

  always_ff @(posedge clk or negedge n_rst) begin : p_flags
    if (!n_rst) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else if (clear) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      if (push_rej) ovf_flag <= 1'b1;
      if (pop_rej)  unf_flag <= 1'b1;
    end
  end

  assign overflow  = ovf_flag;
  assign underflow = unf_flag;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

`default_nettype wire
